ellipse_pixel_writer: RTL and testbench



---
 rtl/ellipse_pixel_writer.sv | 124 ++++++++++++
 tb/tb_ellipse_pixel_writer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/ellipse_pixel_writer.sv
// Expands one first-quadrant ellipse point into its four mirrored pixels,
// drops axis duplicates, clips to the raster and issues frame-buffer writes.
module ellipse_pixel_writer #(
  parameter int H_RES   = 640,
  parameter int V_RES   = 480,
  parameter int ADDR_W  = 19,
  parameter int COLOR_W = 8
) (
  input  logic               clk,
  input  logic               rst_,
  input  logic               pt_valid,
  output logic               pt_ready,
  input  logic [9:0]         pt_x,
  input  logic [9:0]         pt_y,
  input  logic               pt_last,
  input  logic [9:0]         x0_in,
  input  logic [9:0]         y0_in,
  input  logic [COLOR_W-1:0] color_in,
  output logic               fb_we,
  input  logic               fb_ready,
  output logic [ADDR_W-1:0]  fb_addr,
  output logic [COLOR_W-1:0] fb_data,
  output logic               busy,
  output logic               done
);

  typedef enum logic {IDLE, EMIT} state_e;

  state_e             state_q, state_d;
  logic [1:0]         q_q, q_d;
  logic [9:0]         x_q, x_d, y_q, y_d, x0_q, x0_d, y0_q, y0_d;
  logic [COLOR_W-1:0] color_q, color_d;
  logic               last_q, last_d;
  logic               done_q, done_d;

  logic               x_neg, y_neg, suppress, advance;
  logic [11:0]        px, py;

  // Quadrants 1,2 mirror x; quadrants 2,3 mirror y.
  always_comb begin
    x_neg = q_q[0] ^ q_q[1];
    y_neg = q_q[1];
    px = x_neg ? ({2'b00, x0_q} - {2'b00, x_q}) : ({2'b00, x0_q} + {2'b00, x_q});
    py = y_neg ? ({2'b00, y0_q} - {2'b00, y_q}) : ({2'b00, y0_q} + {2'b00, y_q});
    suppress = (x_neg && (x_q == 10'd0)) || (y_neg && (y_q == 10'd0))
            || px[11] || (px[10:0] >= 11'(H_RES))
            || py[11] || (py[10:0] >= 11'(V_RES));
    fb_addr = ADDR_W'(py[10:0]) * ADDR_W'(H_RES) + ADDR_W'(px[10:0]);
    fb_data = color_q;
  end

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    q_d      = q_q;
    x_d      = x_q;
    y_d      = y_q;
    x0_d     = x0_q;
    y0_d     = y0_q;
    color_d  = color_q;
    last_d   = last_q;
    done_d   = 1'b0;
    pt_ready = 1'b0;
    busy     = 1'b0;
    fb_we    = 1'b0;
    advance  = 1'b0;
    unique case (state_q)
      IDLE: begin
        pt_ready = 1'b1;
        if (pt_valid) begin
          x_d     = pt_x;
          y_d     = pt_y;
          x0_d    = x0_in;
          y0_d    = y0_in;
          color_d = color_in;
          last_d  = pt_last;
          q_d     = 2'd0;
          state_d = EMIT;
        end
      end
      EMIT: begin
        busy    = 1'b1;
        fb_we   = !suppress;
        advance = !fb_we || fb_ready;
        if (advance) begin
          q_d = q_q + 2'd1;
          if (q_q == 2'd3) begin
            state_d = IDLE;
            done_d  = last_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign done = done_q;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q <= IDLE;
      q_q     <= 2'd0;
      x_q     <= '0;
      y_q     <= '0;
      x0_q    <= '0;
      y0_q    <= '0;
      color_q <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      x_q     <= x_d;
      y_q     <= y_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      color_q <= color_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_ellipse_pixel_writer.sv
// Directed, table-driven bench for ellipse_pixel_writer with hand sequences
// for backpressure and reset abort.
module tb_ellipse_pixel_writer;

  logic        clk = 1'b0;
  logic        rst_;
  logic        pt_valid, pt_ready, pt_last;
  logic [9:0]  pt_x, pt_y, x0_in, y0_in;
  logic [7:0]  color_in;
  logic        fb_we, fb_ready, busy, done;
  logic [18:0] fb_addr;
  logic [7:0]  fb_data;

  int checks   = 0;
  int failures = 0;
  int wr_count = 0;

  always #5 clk = ~clk;

  ellipse_pixel_writer dut (
    .clk(clk), .rst_(rst_),
    .pt_valid(pt_valid), .pt_ready(pt_ready),
    .pt_x(pt_x), .pt_y(pt_y), .pt_last(pt_last),
    .x0_in(x0_in), .y0_in(y0_in), .color_in(color_in),
    .fb_we(fb_we), .fb_ready(fb_ready), .fb_addr(fb_addr), .fb_data(fb_data),
    .busy(busy), .done(done)
  );

  // Completed writes: handshake seen at a rising edge while out of reset.
  always @(posedge clk) if (rst_ && fb_we === 1'b1 && fb_ready === 1'b1) wr_count++;

  typedef struct {
    logic [9:0]  x0, y0, px, py;
    logic        last;
    logic [3:0]  we;
    logic [18:0] a0, a1, a2, a3;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [18:0] exp_addr(input vec_t v, input int k);
    case (k)
      0: return v.a0;
      1: return v.a1;
      2: return v.a2;
      default: return v.a3;
    endcase
  endfunction

  // Present a point in an idle cycle; returns after the accepting edge.
  task automatic send_point(input vec_t v, input logic [7:0] col);
    @(negedge clk);
    check("idle_pt_ready", pt_ready, 1);
    check("idle_done_low", done, 0);
    pt_valid = 1'b1;
    x0_in = v.x0; y0_in = v.y0; pt_x = v.px; pt_y = v.py;
    pt_last = v.last; color_in = col;
    @(posedge clk);
    #1;
    pt_valid = 1'b0;
    x0_in = 10'd0; y0_in = 10'd0; pt_x = 10'd7; pt_y = 10'd9;
    pt_last = ~v.last; color_in = ~col;
  endtask

  task automatic apply_vec(input vec_t v, input logic [7:0] col);
    int start;
    int nexp;
    start = wr_count;
    nexp  = 0;
    send_point(v, col);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("q%0d_fb_we", k), fb_we, v.we[k]);
      check($sformatf("q%0d_busy", k), busy, 1);
      check($sformatf("q%0d_pt_ready", k), pt_ready, 0);
      if (v.we[k]) begin
        nexp++;
        check($sformatf("q%0d_fb_addr", k), fb_addr, exp_addr(v, k));
        check($sformatf("q%0d_fb_data", k), fb_data, col);
      end
    end
    @(negedge clk);
    check("end_pt_ready", pt_ready, 1);
    check("end_busy", busy, 0);
    check("end_done", done, v.last);
    check("write_count", wr_count - start, nexp);
  endtask

  initial begin
    int start;
    vecs[0] = '{10'd320, 10'd240, 10'd3, 10'd4, 1'b0, 4'b1111, 19'd156483, 19'd156477, 19'd151357, 19'd151363};
    vecs[1] = '{10'd320, 10'd240, 10'd0, 10'd5, 1'b0, 4'b1001, 19'd157120, 19'd0, 19'd0, 19'd150720};
    vecs[2] = '{10'd320, 10'd240, 10'd5, 10'd0, 1'b0, 4'b0011, 19'd153925, 19'd153915, 19'd0, 19'd0};
    vecs[3] = '{10'd320, 10'd240, 10'd0, 10'd0, 1'b0, 4'b0001, 19'd153920, 19'd0, 19'd0, 19'd0};
    vecs[4] = '{10'd2,   10'd1,   10'd5, 10'd3, 1'b0, 4'b0001, 19'd2567, 19'd0, 19'd0, 19'd0};
    vecs[5] = '{10'd638, 10'd100, 10'd3, 10'd0, 1'b0, 4'b0010, 19'd0, 19'd64635, 19'd0, 19'd0};
    vecs[6] = '{10'd320, 10'd240, 10'd3, 10'd4, 1'b1, 4'b1111, 19'd156483, 19'd156477, 19'd151357, 19'd151363};
    vecs[7] = '{10'd320, 10'd240, 10'd3, 10'd4, 1'b0, 4'b1111, 19'd156483, 19'd156477, 19'd151357, 19'd151363};

    rst_ = 1'b0; pt_valid = 1'b0; pt_last = 1'b0; fb_ready = 1'b1;
    pt_x = '0; pt_y = '0; x0_in = '0; y0_in = '0; color_in = '0;
    #12;
    check("rst_pt_ready", pt_ready, 1);
    check("rst_fb_we", fb_we, 0);
    check("rst_fb_addr", fb_addr, 0);
    check("rst_fb_data", fb_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(negedge clk);
    rst_ = 1'b1;

    for (int i = 0; i < 8; i++) apply_vec(vecs[i], 8'hA0 + 8'(i));

    // Backpressure: frame buffer stalls for 3 cycles while q=1.
    start = wr_count;
    send_point(vecs[0], 8'h5C);
    @(negedge clk);
    check("bp_q0_addr", fb_addr, 156483);
    @(posedge clk);
    #1 fb_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("bp_stall_we", fb_we, 1);
      check("bp_stall_addr", fb_addr, 156477);
      check("bp_stall_data", fb_data, 8'h5C);
      check("bp_stall_pt_ready", pt_ready, 0);
      @(posedge clk);
    end
    #1 fb_ready = 1'b1;
    @(negedge clk);
    check("bp_q1_release_addr", fb_addr, 156477);
    @(negedge clk);
    check("bp_q2_addr", fb_addr, 151357);
    check("bp_q2_pt_ready", pt_ready, 0);
    @(negedge clk);
    check("bp_q3_addr", fb_addr, 151363);
    @(negedge clk);
    check("bp_write_count", wr_count - start, 4);
    check("bp_end_pt_ready", pt_ready, 1);

    // Reset abort during q=1 of a last point.
    send_point(vecs[6], 8'h33);
    @(negedge clk);
    @(negedge clk);
    check("abort_q1_we", fb_we, 1);
    start = wr_count;
    #2 rst_ = 1'b0;
    #1;
    check("abort_fb_we_async", fb_we, 0);
    check("abort_busy", busy, 0);
    @(negedge clk);
    rst_ = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("abort_after_we", fb_we, 0);
      check("abort_after_busy", busy, 0);
      check("abort_after_done", done, 0);
      check("abort_after_pt_ready", pt_ready, 1);
    end
    check("abort_no_writes", wr_count - start, 0);

    apply_vec(vecs[0], 8'h77);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
